// File: rtl/dual_port_ram.sv
// dual_port_ram
//   Simple-dual-port synchronous RAM with one write port and one read port on
//   a shared clock. It supports per-byte write enables and a selectable
//   same-address read-during-write policy. An optional output register can be
//   added. Writes to addresses at or beyond DEPTH are dropped, and reads of
//   those addresses return zero. A clear sequencer sweeps INIT_VALUE through
//   the whole array after reset and on request.
//
// Ports
//   clk     rising-edge clock
//   rst     asynchronous active-high reset of control/output state (not memory)
//   clr     start (or restart) a clear sweep
//   ready   high when accesses are accepted (FSM in READY)
//   we      write request
//   waddr   write address
//   be      byte-lane write enables, lane i = bits [i*BYTE_WIDTH +: BYTE_WIDTH]
//   wdata   write data
//   re      read request
//   raddr   read address
//   rdata   read data, held between reads
//   rvalid  one-cycle pulse per accepted read, 1 + OUT_REG cycles later
//
// Handshake: there is no backpressure beyond ready. A request presented
// while ready=1 is accepted on that edge. A request presented while
// ready=0 is dropped silently.
module dual_port_ram #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    BYTE_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 4,
    parameter int                    DEPTH          = 1 << ADDR_WIDTH,
    parameter int                    RDW_MODE       = 0,
    parameter int                    OUT_REG        = 0,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clr,
    output logic                               ready,
    input  logic                               we,
    input  logic [ADDR_WIDTH-1:0]              waddr,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   be,
    input  logic [DATA_WIDTH-1:0]              wdata,
    input  logic                               re,
    input  logic [ADDR_WIDTH-1:0]              raddr,
    output logic [DATA_WIDTH-1:0]              rdata,
    output logic                               rvalid
);

    localparam int NB = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] cnt, cnt_next;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_ok;
    logic                  rd_ok;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd1;
    logic                  rv1;

    // ---------------- clear sequencer ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RESET_STATE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_CLEAR: begin
                // The current cnt is still written this cycle. A clr only
                // rewinds the pointer for the following cycle.
                if (clr) begin
                    cnt_next = '0;
                end else if (cnt == LAST_ADDR) begin
                    state_next = ST_READY;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_READY: begin
                if (clr) begin
                    state_next = ST_CLEAR;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = RESET_STATE;
                cnt_next   = '0;
            end
        endcase
    end

    assign ready = (state == ST_READY);
    assign wr_ok = ready && we && (int'(waddr) < DEPTH);
    assign rd_ok = ready && re;

    // ---------------- storage ----------------
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[cnt] <= INIT_VALUE;
        end else if (wr_ok) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Word returned by a read accepted this cycle. The memory read is the
    // pre-write value, so old-data mode needs no extra logic. New-data mode
    // overlays the enabled write lanes when the addresses match.
    always_comb begin
        rd_word = '0;
        if (int'(raddr) < DEPTH) begin
            rd_word = mem[raddr];
            if ((RDW_MODE != 0) && wr_ok && (waddr == raddr)) begin
                for (int i = 0; i < NB; i++) begin
                    if (be[i]) begin
                        rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end
    end

    // ---------------- read pipeline ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd1 <= '0;
            rv1 <= 1'b0;
        end else begin
            rv1 <= rd_ok;
            if (rd_ok) begin
                rd1 <= rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] rd2;
            logic                  rv2;
            // Not gated by ready, so reads accepted before a clr still drain.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd2 <= '0;
                    rv2 <= 1'b0;
                end else begin
                    rv2 <= rv1;
                    if (rv1) begin
                        rd2 <= rd1;
                    end
                end
            end
            assign rdata  = rd2;
            assign rvalid = rv2;
        end else begin : g_no_out_reg
            assign rdata  = rd1;
            assign rvalid = rv1;
        end
    endgenerate

endmodule

// File: tb/tb_dual_port_ram.sv
// tb_dual_port_ram
//   Drives three RAM instances from one shared stimulus stream.
//     A: 32-bit, DEPTH=10, old-data read-during-write, output register.
//     B: 32-bit, DEPTH=16, new-data read-during-write, no output register.
//     C: defaults with CLEAR_ON_RESET=0. Only its reset state is inspected.
//   A behavioural model of A and B is checked on every negative edge. Directed
//   sequences with hand-computed literals pin the model. Randomized traffic
//   follows.
module tb_dual_port_ram;

  localparam logic [31:0] INIT_A = 32'h5A5A_0F0F;
  localparam logic [31:0] INIT_B = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [3:0]  waddr = '0;
  logic [3:0]  raddr = '0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;

  logic        ready_a, ready_b, ready_c;
  logic        rvalid_a, rvalid_b, rvalid_c;
  logic [31:0] rdata_a, rdata_b;
  logic [7:0]  rdata_c;

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  dual_port_ram #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(10),
                  .RDW_MODE(0), .OUT_REG(1), .CLEAR_ON_RESET(1), .INIT_VALUE(INIT_A))
    dut_a (.clk(clk), .rst(rst), .clr(clr), .ready(ready_a), .we(we), .waddr(waddr),
           .be(be), .wdata(wdata), .re(re), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a));

  dual_port_ram #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16),
                  .RDW_MODE(1), .OUT_REG(0), .CLEAR_ON_RESET(1), .INIT_VALUE(INIT_B))
    dut_b (.clk(clk), .rst(rst), .clr(clr), .ready(ready_b), .we(we), .waddr(waddr),
           .be(be), .wdata(wdata), .re(re), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b));

  dual_port_ram #(.CLEAR_ON_RESET(0))
    dut_c (.clk(clk), .rst(rst), .clr(clr), .ready(ready_c), .we(we), .waddr(waddr),
           .be(be[0]), .wdata(wdata[7:0]), .re(re), .raddr(raddr), .rdata(rdata_c), .rvalid(rvalid_c));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model (A = index 0, B = index 1) ----------------
  typedef struct {
    int          dut;
    int          due;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int          depth_p [2] = '{10, 16};
  int          rdw_p   [2] = '{0, 1};
  int          oreg_p  [2] = '{1, 0};
  logic [31:0] init_p  [2] = '{INIT_A, INIT_B};
  bit          m_ready [2];
  int          m_cnt   [2];
  logic [31:0] m_rdata [2];
  bit          m_rvalid[2];
  logic [31:0] m_mem   [2][16];
  int          cyc = 0;
  bit          model_live = 1'b0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int l = 0; l < 4; l++) if (b[l]) r[8*l +: 8] = nw[8*l +: 8];
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    bit          rd_ok, wr_ok, found;
    logic [31:0] v;
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < 2; i++) begin
        m_ready[i]  = 1'b0;
        m_cnt[i]    = 0;
        m_rdata[i]  = '0;
        m_rvalid[i] = 1'b0;
      end
      model_live = 1'b1;
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        rd_ok = m_ready[i] && re;
        wr_ok = m_ready[i] && we && (int'(waddr) < depth_p[i]);
        if (rd_ok) begin
          v = (int'(raddr) < depth_p[i]) ? m_mem[i][raddr] : 32'h0;
          if (rdw_p[i] == 1 && wr_ok && waddr == raddr) v = merge(v, wdata, be);
          exp_q.push_back('{i, cyc + oreg_p[i], v});
        end
        if (wr_ok) m_mem[i][waddr] = merge(m_mem[i][waddr], wdata, be);
        if (!m_ready[i]) m_mem[i][m_cnt[i]] = init_p[i];
        if (clr) begin
          m_ready[i] = 1'b0;
          m_cnt[i]   = 0;
        end else if (!m_ready[i]) begin
          if (m_cnt[i] == depth_p[i] - 1) m_ready[i] = 1'b1;
          else m_cnt[i]++;
        end
        m_rvalid[i] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
          if (!found && exp_q[k].dut == i) begin
            found = 1'b1;
            if (exp_q[k].due == cyc) begin
              m_rvalid[i] = 1'b1;
              m_rdata[i]  = exp_q[k].val;
              exp_q.delete(k);
            end
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_live) begin
      check("ready_a",  32'(ready_a),  32'(m_ready[0]));
      check("rvalid_a", 32'(rvalid_a), 32'(m_rvalid[0]));
      check("rdata_a",  rdata_a,       m_rdata[0]);
      check("ready_b",  32'(ready_b),  32'(m_ready[1]));
      check("rvalid_b", 32'(rvalid_b), 32'(m_rvalid[1]));
      check("rdata_b",  rdata_b,       m_rdata[1]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_access(input logic w, input logic [3:0] wa, input logic [3:0] b,
                           input logic [31:0] wd, input logic r, input logic [3:0] ra,
                           output logic [31:0] d_a, output logic v_a,
                           output logic [31:0] d_b, output logic v_b);
    we = w; waddr = wa; be = b; wdata = wd; re = r; raddr = ra;
    @(posedge clk); #2;
    we = 1'b0; re = 1'b0;
    @(negedge clk);
    d_b = rdata_b; v_b = rvalid_b;
    @(negedge clk);
    d_a = rdata_a; v_a = rvalid_a;
  endtask

  // Counts edges until each instance reports ready. -1 means the bound expired.
  task automatic wait_ready(output int na, output int nb);
    na = -1; nb = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (ready_a && na < 0) na = k;
      if (ready_b && nb < 0) nb = k;
      if (na > 0 && nb > 0) break;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [31:0] da, db;
    logic        va, vb;
    int          na, nb;
    bit          any_valid;
    logic [31:0] words [3];
    words[0] = 32'h0000_1000;
    words[1] = 32'h0000_2001;
    words[2] = 32'h0000_3002;

    // reset state
    @(negedge clk);
    check("reset ready_a", 32'(ready_a), 32'd0);
    check("reset ready_b", 32'(ready_b), 32'd0);
    check("reset ready_c", 32'(ready_c), 32'd1);
    check("reset rvalid_c", 32'(rvalid_c), 32'd0);
    check("reset rdata_c", 32'(rdata_c), 32'd0);
    check("reset rdata_b", rdata_b, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;

    // sweep length after reset
    wait_ready(na, nb);
    check("sweep len a", 32'(na), 32'd10);
    check("sweep len b", 32'(nb), 32'd16);

    // first ready cycle returns INIT_VALUE
    do_access(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd0, da, va, db, vb);
    check("init read a", da, INIT_A);
    check("init valid a", 32'(va), 32'd1);
    check("init read b", db, INIT_B);
    check("init valid b", 32'(vb), 32'd1);

    // byte enables
    do_access(1'b1, 4'd3, 4'hF, 32'h1122_3344, 1'b0, 4'd0, da, va, db, vb);
    do_access(1'b1, 4'd3, 4'h5, 32'hAABB_CCDD, 1'b0, 4'd0, da, va, db, vb);
    do_access(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd3, da, va, db, vb);
    check("byte en a", da, 32'h11BB_33DD);
    check("byte en b", db, 32'h11BB_33DD);

    // read during write
    do_access(1'b1, 4'd5, 4'hF, 32'h10, 1'b0, 4'd0, da, va, db, vb);
    do_access(1'b1, 4'd5, 4'hF, 32'h20, 1'b1, 4'd5, da, va, db, vb);
    check("rdw old a", da, 32'h10);
    check("rdw new b", db, 32'h20);
    do_access(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd5, da, va, db, vb);
    check("rdw after a", da, 32'h20);
    check("rdw after b", db, 32'h20);

    // latency with back-to-back reads of 0,1,2
    for (int k = 0; k < 3; k++)
      do_access(1'b1, 4'(k), 4'hF, words[k], 1'b0, 4'd0, da, va, db, vb);
    re = 1'b1; raddr = 4'd0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); @(negedge clk);
      check("lat valid b", 32'(rvalid_b), (k <= 3) ? 32'd1 : 32'd0);
      check("lat valid a", 32'(rvalid_a), (k >= 2) ? 32'd1 : 32'd0);
      if (k <= 3) check("lat data b", rdata_b, words[k-1]);
      if (k >= 2) check("lat data a", rdata_a, words[k-2]);
      if (k < 3) raddr = 4'(k);
      else re = 1'b0;
    end

    // out-of-range address (only A has DEPTH=10)
    do_access(1'b1, 4'd12, 4'hF, 32'hDEAD_BEEF, 1'b0, 4'd0, da, va, db, vb);
    do_access(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd12, da, va, db, vb);
    check("range data a", da, 32'h0);
    check("range valid a", 32'(va), 32'd1);
    check("range data b", db, 32'hDEAD_BEEF);

    // clr, gated accesses during sweep, restart at sweep cycle 7
    clr = 1'b1;
    @(posedge clk); #2;
    clr = 1'b0;
    we = 1'b1; waddr = 4'd1; be = 4'hF; wdata = 32'hFFFF_FFFF; re = 1'b1; raddr = 4'd2;
    any_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      any_valid = any_valid | rvalid_a | rvalid_b;
      if (k == 7) begin #1; clr = 1'b1; end
    end
    @(posedge clk); #1;
    any_valid = any_valid | rvalid_a | rvalid_b;
    #1;
    clr = 1'b0; we = 1'b0; re = 1'b0;
    check("clear gating rvalid", 32'(any_valid), 32'd0);
    wait_ready(na, nb);
    check("restart len a", 32'(na), 32'd10);
    check("restart len b", 32'(nb), 32'd16);
    do_access(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd1, da, va, db, vb);
    check("after clr a", da, INIT_A);
    check("after clr b", db, INIT_B);

    // rst while a read is in flight
    re = 1'b1; raddr = 4'd0;
    @(posedge clk); #2;
    re = 1'b0; rst = 1'b1;
    #1;
    check("rst rvalid a", 32'(rvalid_a), 32'd0);
    check("rst rvalid b", 32'(rvalid_b), 32'd0);
    check("rst rdata a", rdata_a, 32'd0);
    check("rst rdata b", rdata_b, 32'd0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    wait_ready(na, nb);
    check("post rst len b", 32'(nb), 32'd16);

    // rst at sweep cycle 4
    #1; clr = 1'b1;
    @(posedge clk); #2;
    clr = 1'b0;
    repeat (4) @(posedge clk);
    #2; rst = 1'b1;
    #1;
    check("mid sweep ready b", 32'(ready_b), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    wait_ready(na, nb);
    check("mid sweep len a", 32'(na), 32'd10);
    check("mid sweep len b", 32'(nb), 32'd16);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      @(posedge clk); #2;
      rst   = ($urandom_range(0, 299) == 0);
      clr   = ($urandom_range(0, 79) == 0);
      we    = 1'($urandom_range(0, 1));
      re    = 1'($urandom_range(0, 1));
      waddr = 4'($urandom_range(0, 15));
      raddr = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
      be    = 4'($urandom_range(0, 15));
      wdata = $urandom();
    end
    @(posedge clk); #2;
    rst = 1'b0; clr = 1'b0; we = 1'b0; re = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
